// File: rtl/handshake_coeff_pkg.sv
// Shared definitions for the softclip coefficient arbiter: FSM states and the
// constant coefficient table with its range-checked lookup.
package handshake_coeff_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam int COEFF_W     = 24;
  localparam int COEFF_DEPTH = 6;

  localparam logic [COEFF_W-1:0] COEFF_TABLE [COEFF_DEPTH] = '{
    24'hF5D1B2,
    24'h0A2E4E,
    24'h400000,
    24'hC00000,
    24'h155555,
    24'hEAAAAB
  };

  // Out-of-range indices read as zero rather than aliasing into the table.
  function automatic logic [COEFF_W-1:0] coeff_lookup(input int unsigned idx);
    logic [COEFF_W-1:0] val;
    val = '0;
    if (idx < COEFF_DEPTH) begin
      val = COEFF_TABLE[idx];
    end
    return val;
  endfunction

endpackage

// File: rtl/handshake_coeff_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N_REQ. Produces a one-hot grant and the encoded winner.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] winner,
  output logic             any
);

  int cand;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        winner      = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/handshake_coeff_arbiter.sv
// Round-robin shared coefficient source: N_REQ valid/ready index channels in,
// one registered tagged coefficient channel out, sticky out-of-range flag.
module handshake_coeff_arbiter
  import handshake_coeff_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_WIDTH  = 24,
  parameter int IDX_WIDTH   = 3,
  parameter int TABLE_DEPTH = 6,
  parameter int TAG_WIDTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*IDX_WIDTH-1:0] req_idx,
  output logic [DATA_WIDTH-1:0]      outs,
  output logic [TAG_WIDTH-1:0]       outs_tag,
  output logic                       outs_valid,
  input  logic                       outs_ready,
  output logic                       err_oob
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t                  state_reg;
  logic [PTR_W-1:0]        ptr_reg;
  logic [PTR_W-1:0]        ptr_next;
  logic [DATA_WIDTH-1:0]   outs_reg;
  logic [TAG_WIDTH-1:0]    outs_tag_reg;
  logic                    outs_valid_reg;
  logic                    err_oob_reg;

  logic [N_REQ-1:0]        grant;
  logic [PTR_W-1:0]        winner;
  logic                    any_req;
  logic                    can_load;
  logic                    accept;
  logic                    drain;
  logic                    win_oob;
  logic [IDX_WIDTH-1:0]    win_idx;
  logic [DATA_WIDTH-1:0]   win_coeff;
  logic [IDX_WIDTH-1:0]    idx_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_idx
    assign idx_arr[gi] = req_idx[gi*IDX_WIDTH +: IDX_WIDTH];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req    (req_valid),
    .ptr    (ptr_reg),
    .grant  (grant),
    .winner (winner),
    .any    (any_req)
  );

  // The output slot can take a new result when empty or being drained this cycle.
  assign can_load = (state_reg == ST_EMPTY) || (outs_valid_reg && outs_ready);
  assign drain    = outs_valid_reg && outs_ready;
  assign accept   = rst && can_load && any_req;

  // Gated by rst so no requester sees an accept while reset is held.
  assign req_ready = (rst && can_load) ? grant : '0;

  assign win_idx   = idx_arr[winner];
  assign win_oob   = int'(win_idx) >= TABLE_DEPTH;
  assign win_coeff = win_oob ? '0 : DATA_WIDTH'(coeff_lookup(int'(win_idx)));
  assign ptr_next  = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_EMPTY;
      ptr_reg        <= '0;
      outs_reg       <= '0;
      outs_tag_reg   <= '0;
      outs_valid_reg <= 1'b0;
      err_oob_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_reg      <= ST_FULL;
            outs_valid_reg <= 1'b1;
          end
        end
        ST_FULL: begin
          // A drain with a concurrent accept stays FULL for back-to-back results.
          if (drain && !accept) begin
            state_reg      <= ST_EMPTY;
            outs_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg      <= ST_EMPTY;
          outs_valid_reg <= 1'b0;
        end
      endcase

      if (accept) begin
        outs_reg     <= win_coeff;
        outs_tag_reg <= TAG_WIDTH'(winner);
        ptr_reg      <= ptr_next;
        if (win_oob) begin
          err_oob_reg <= 1'b1;
        end
      end
    end
  end

  assign outs       = outs_reg;
  assign outs_tag   = outs_tag_reg;
  assign outs_valid = outs_valid_reg;
  assign err_oob    = err_oob_reg;

endmodule

// File: tb/tb_handshake_coeff_arbiter.sv
// Directed vector bench for handshake_coeff_arbiter: table of per-cycle
// stimulus with hand-computed expectations, plus an asynchronous reset sequence.
module tb_handshake_coeff_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_idx;
  logic [23:0] outs;
  logic [1:0]  outs_tag;
  logic        outs_valid;
  logic        outs_ready;
  logic        err_oob;

  int n_vec     = 0;
  int n_checks  = 0;
  int n_miscmp  = 0;

  typedef struct {
    logic [3:0]  rv;
    logic [11:0] idx;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic [23:0] e_outs;
    logic [1:0]  e_tag;
    logic        e_valid;
    logic        e_err;
  } vec_t;

  vec_t vecs [$];

  logic [23:0] ctab [6] = '{24'hF5D1B2, 24'h0A2E4E, 24'h400000,
                            24'hC00000, 24'h155555, 24'hEAAAAB};

  handshake_coeff_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_idx    (req_idx),
    .outs       (outs),
    .outs_tag   (outs_tag),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready),
    .err_oob    (err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] rv, input logic [11:0] idx,
                              input logic ordy, input logic [3:0] e_rdy,
                              input logic [23:0] e_outs, input logic [1:0] e_tag,
                              input logic e_valid, input logic e_err);
    vec_t v;
    v.rv = rv; v.idx = idx; v.ordy = ordy; v.e_rdy = e_rdy;
    v.e_outs = e_outs; v.e_tag = e_tag; v.e_valid = e_valid; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven just after a rising edge; req_ready is sampled at the
  // falling edge, registered outputs 1ns after the following rising edge.
  task automatic apply(input int n, input vec_t v);
    req_valid  = v.rv;
    req_idx    = v.idx;
    outs_ready = v.ordy;
    @(negedge clk);
    chk($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(v.e_rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d outs", n), 32'(outs), 32'(v.e_outs));
    chk($sformatf("v%0d outs_tag", n), 32'(outs_tag), 32'(v.e_tag));
    chk($sformatf("v%0d outs_valid", n), 32'(outs_valid), 32'(v.e_valid));
    chk($sformatf("v%0d err_oob", n), 32'(err_oob), 32'(v.e_err));
    n_vec++;
    $display("vec %0d: rv=%b idx=%h ordy=%b -> rdy=%b outs=%h tag=%0d valid=%b err=%b",
             n, v.rv, v.idx, v.ordy, req_ready, outs, outs_tag, outs_valid, err_oob);
  endtask

  initial begin
    // Fairness: all four valid with idx 2, round-robin from ptr 0.
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(4'hF, 12'h492, 1'b1, 4'(1 << (i % 4)), 24'h400000, 2'(i % 4), 1'b1, 1'b0));
    end
    // Single request reloading while the previous result drains.
    vecs.push_back(mk(4'b0001, 12'h000, 1'b1, 4'b0001, 24'hF5D1B2, 2'd0, 1'b1, 1'b0));
    // Drain to empty, then idle; outs/tag hold their last values.
    vecs.push_back(mk(4'b0000, 12'h000, 1'b1, 4'b0000, 24'hF5D1B2, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0000, 12'h000, 1'b1, 4'b0000, 24'hF5D1B2, 2'd0, 1'b0, 1'b0));
    // Requester 1 fills the register (ptr was 1).
    vecs.push_back(mk(4'b0010, 12'h008, 1'b1, 4'b0010, 24'h0A2E4E, 2'd1, 1'b1, 1'b0));
    // Back-pressure for 3 cycles with req 2 (idx 3) and req 3 (idx 4) waiting.
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(mk(4'b1100, 12'h8C0, 1'b0, 4'b0000, 24'h0A2E4E, 2'd1, 1'b1, 1'b0));
    end
    vecs.push_back(mk(4'b1100, 12'h8C0, 1'b1, 4'b0100, 24'hC00000, 2'd2, 1'b1, 1'b0));
    vecs.push_back(mk(4'b1000, 12'h8C0, 1'b1, 4'b1000, 24'h155555, 2'd3, 1'b1, 1'b0));
    // Out-of-range idx 7 from requester 3.
    vecs.push_back(mk(4'b1000, 12'hE00, 1'b1, 4'b1000, 24'h000000, 2'd3, 1'b1, 1'b1));
    // Ten normal transactions from requester 0; err_oob stays set.
    for (int k = 0; k < 10; k++) begin
      vecs.push_back(mk(4'b0001, 12'(k % 6), 1'b1, 4'b0001, ctab[k % 6], 2'd0, 1'b1, 1'b1));
    end
    // Drain, then a later request sees 1-cycle latency (ptr 1 -> winner 2).
    vecs.push_back(mk(4'b0000, 12'h000, 1'b1, 4'b0000, 24'hC00000, 2'd0, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0100, 12'h140, 1'b1, 4'b0100, 24'hEAAAAB, 2'd2, 1'b1, 1'b1));

    rst        = 1'b0;
    req_valid  = 4'hF;
    req_idx    = 12'h000;
    outs_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset outs", 32'(outs), 32'h0);
    chk("reset outs_tag", 32'(outs_tag), 32'h0);
    chk("reset outs_valid", 32'(outs_valid), 32'h0);
    chk("reset err_oob", 32'(err_oob), 32'h0);
    chk("reset req_ready", 32'(req_ready), 32'h0);
    $display("reset: outs=%h tag=%0d valid=%b err=%b rdy=%b", outs, outs_tag, outs_valid, err_oob, req_ready);
    rst = 1'b1;

    for (int n = 0; n < vecs.size(); n++) begin
      apply(n, vecs[n]);
    end

    // Asynchronous reset while FULL with err_oob set: visible before any edge.
    req_valid  = 4'hF;
    req_idx    = 12'h000;
    outs_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async rst outs_valid", 32'(outs_valid), 32'h0);
    chk("async rst err_oob", 32'(err_oob), 32'h0);
    chk("async rst req_ready", 32'(req_ready), 32'h0);
    chk("async rst outs", 32'(outs), 32'h0);
    chk("async rst outs_tag", 32'(outs_tag), 32'h0);
    n_vec++;
    $display("async reset: outs=%h tag=%0d valid=%b err=%b rdy=%b", outs, outs_tag, outs_valid, err_oob, req_ready);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    outs_ready = 1'b1;
    @(negedge clk);
    chk("post-reset req_ready", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    chk("post-reset outs", 32'(outs), 32'hF5D1B2);
    chk("post-reset outs_tag", 32'(outs_tag), 32'h0);
    chk("post-reset outs_valid", 32'(outs_valid), 32'h1);
    n_vec++;
    $display("post-reset accept: outs=%h tag=%0d valid=%b", outs, outs_tag, outs_valid);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
